// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle multiply/divide unit with HI/LO registers
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  func,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        neg_q, neg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [32:0] div_tmp, div_diff;
  logic        div_ge;
  logic [63:0] acc_step, prod_fix;
  logic [31:0] quo_fix, rem_fix;

  assign signed_op = ~func[0];
  assign mag_a     = (signed_op && A[31]) ? (~A + 32'd1) : A;
  assign mag_b     = (signed_op && B[31]) ? (~B + 32'd1) : B;

  // acc holds {partial product, multiplier} for mult and {remainder, dividend/quotient} for div
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mcand_q} : 33'd0);
    div_tmp  = {acc_q[63:32], acc_q[31]};
    div_ge   = (div_tmp >= {1'b0, mcand_q});
    div_diff = div_tmp - {1'b0, mcand_q};
    if (is_div_q) begin
      acc_step = {(div_ge ? div_diff[31:0] : div_tmp[31:0]), acc_q[30:0], div_ge};
    end else begin
      acc_step = {mul_sum, acc_q[31:1]};
    end
    prod_fix = neg_q  ? (~acc_step + 64'd1) : acc_step;
    quo_fix  = neg_q  ? (~acc_step[31:0] + 32'd1) : acc_step[31:0];
    rem_fix  = rneg_q ? (~acc_step[63:32] + 32'd1) : acc_step[63:32];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          cnt_d    = 5'd0;
          is_div_d = func[1];
          // div by zero keeps the all-ones quotient un-negated
          neg_d    = signed_op && (A[31] ^ B[31]) && (!func[1] || (B != 32'd0));
          rneg_d   = signed_op && A[31] && func[1];
          mcand_d  = func[1] ? mag_b : mag_a;
          acc_d    = {32'd0, (func[1] ? mag_a : mag_b)};
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (is_div_q) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
          end else begin
            hi_d = prod_fix[63:32];
            lo_d = prod_fix[31:0];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      mcand_q  <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative multiply/divide unit that executes MIPS `mult`, `multu`, `div` and `divu` and holds the HI/LO register pair. It is the multi-cycle counterpart to the single-cycle ALU. It consumes the same 32-bit signed operand pair `A`/`B` from the execute stage, and returns results through HI/LO rather than `out`. The pipeline issues through a start/busy handshake, stalls `mfhi`/`mflo` while `busy` is high, and writes HI/LO directly for `mthi`/`mtlo`.

## Interface
- No parameters; data width fixed at 32.
- `clk` — input, 1 — single clock, rising-edge.
- `rst_n` — input, 1 — reset, asynchronous and active-low.
- `start` — input, 1 — issue request; sampled on `clk` rising edge.
- `func` — input, 2 — operation: 0 `mult`, 1 `multu`, 2 `div`, 3 `divu`; sampled with `start`.
- `A`, `B` — input, 32 each — operands, signed or unsigned per `func`; sampled with `start`.
- `mthi`, `mtlo` — input, 1 each — write `A` into HI / LO.
- `busy` — output, 1 — operation in progress.
- `done` — output, 1 — one-cycle pulse; HI/LO valid from this cycle.
- `hi`, `lo` — output, 32 each — HI/LO register contents.

## Operation
- States:
  - IDLE: `busy`=0.
  - RUN: `busy`=1; 5-bit iteration counter counts 0..31.
- IDLE → RUN on `start`=1. On that edge the unit latches `func`, the operand magnitudes and the result signs:
  - Signed ops take the absolute value of each operand.
  - `mult`: result negative when signs differ.
  - `div`: quotient negative when signs differ; remainder takes the sign of `A`.
- RUN, multiply: one radix-2 shift-add step per cycle into a 64-bit accumulator.
- RUN, divide: one restoring step per cycle, with a 32-bit partial remainder and a 32-bit quotient.
- RUN → IDLE on the edge where counter=31. That same edge:
  - applies sign correction (two's-complement negate where needed);
  - writes HI/LO;
  - clears `busy`;
  - sets `done`=1 for exactly one cycle.
- Result placement:
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero (`B`=0, both div ops): LO = 32'hFFFF_FFFF, HI = `A` unchanged. Same 32-cycle latency; no flag raised.
- Signed 32'h8000_0000 / 32'hFFFF_FFFF gives LO = 32'h8000_0000, HI = 0 (natural wrap, no overflow indication).
- `mthi` / `mtlo`: in IDLE with `start`=0, the next edge writes `A` to HI / LO. Both high together writes both.
- HI/LO hold their values at all other times.
- Ignored inputs:
  - `start` while `busy`=1 is ignored; the unit does not queue it.
  - `mthi`/`mtlo` while `busy`=1 are ignored.
  - When `start` and `mthi`/`mtlo` arrive in the same IDLE cycle, `start` wins and the moves are dropped.
- Operand inputs may change freely during RUN; only the values latched at start are used.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter 0, internal operand registers 0.
- Reset asserted mid-operation aborts immediately and asynchronously; all outputs return to reset values.
- Latency, with the start edge as E0:
  - `busy`=1 after E0.
  - Iteration steps occur on E1..E31.
  - Final step plus HI/LO write occur on E32.
  - `busy` falls and `done` rises after E32.
  - Total 32 cycles of `busy`.
- A new `start` is accepted in the `done` cycle, giving a back-to-back issue interval of 33 cycles.
- `done` is never high while `busy`=1.
- `hi`/`lo` are registered outputs; they show no intermediate values during RUN and change only on E32.
- `mthi`/`mtlo` take effect one edge after assertion; the pipeline may read the new value in the following cycle.

## Test plan
- `mult`, A=32'hFFFF_FFFF, B=2 → `done` exactly 32 cycles after start; HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFE. Same operands with `multu` → HI=1, LO=32'hFFFF_FFFE.
- `div`, A=-7 (32'hFFFF_FFF9), B=2 → LO=32'hFFFF_FFFD, HI=32'hFFFF_FFFF. `divu`, A=7, B=2 → LO=3, HI=1.
- `divu`, A=7, B=0 → LO=32'hFFFF_FFFF, HI=7 after 32 cycles. `div`, A=32'h8000_0000, B=32'hFFFF_FFFF → LO=32'h8000_0000, HI=0.
- Issue `mult` 3×5 → the following must all hold:
  - a second `start` with 9×9 at cycle 10 is ignored;
  - `mthi` with A=32'h1234 at cycle 12 is ignored;
  - final HI=0, LO=15;
  - `mtlo` A=32'hABCD in the IDLE cycle after `done` → LO=32'hABCD next cycle, HI=0.
- Assert `rst_n`=0 asynchronously mid-cycle 10 of a `div` → `busy`, `done`, HI, LO = 0 immediately. After release, a fresh `multu` 6×7 gives LO=42 after 32 cycles.
- Same-cycle `start`(`multu` 2×3) and `mthi`(A=32'hFFFF) in IDLE → `mthi` dropped; final HI=0, LO=6. Back-to-back start in the `done` cycle is accepted: `busy` rises the next cycle.
